// File: rtl/async_hs_rx.sv
`timescale 1ns/1ps
// async_hs_rx: synchronous end of a 4-phase bundled-data channel.
// Synchronizes req, captures the bundled word into a FIFO and returns a flop-driven ack.
module async_hs_rx #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_in,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     ack_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    IDLE     = 2'd1,
    ACK_HI   = 2'd2
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic [SYNC_STAGES-1:0]   primed_q;
  logic                     req_s;
  logic                     sync_ok;

  logic [WIDTH-1:0]         mem_q [DEPTH];
  logic [PW-1:0]            wr_ptr_q;
  logic [PW-1:0]            rd_ptr_q;
  logic [PW-1:0]            wr_ptr_d;
  logic [PW-1:0]            rd_ptr_d;
  logic [LW-1:0]            level_q;
  logic [LW-1:0]            level_d;
  logic [WIDTH-1:0]         head_q;
  logic                     valid_q;
  logic                     ack_q;

  logic                     ack_d;
  logic                     push_c;
  logic                     pop_c;
  logic                     full_c;

  // req synchronizer; primed_q marks when req_s carries a real post-reset sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      primed_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], req_in};
      primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign sync_ok = primed_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Full check uses registered level, so a same-cycle pop never enables a push
  assign full_c = (level_q == LW'(DEPTH));

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST_WAIT: if (sync_ok && !req_s)  state_d = IDLE;
      IDLE:     if (req_s && !full_c)   state_d = ACK_HI;
      ACK_HI:   if (!req_s)             state_d = IDLE;
      default:                          state_d = RST_WAIT;
    endcase
  end

  always_comb begin
    push_c = 1'b0;
    ack_d  = 1'b0;
    if (state_q == IDLE && req_s && !full_c) begin
      push_c = 1'b1;
    end
    if (state_d == ACK_HI) begin
      ack_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

  assign pop_c = valid_q && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // head_q always mirrors mem[rd_ptr]; forward data_in when the new word becomes head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= (level_d != '0);
      if (push_c && (wr_ptr_q == rd_ptr_d)) begin
        head_q <= data_in;
      end else begin
        head_q <= mem_q[rd_ptr_d];
      end
    end
  end

  assign ack_out   = ack_q;
  assign out_valid = valid_q;
  assign out_data  = head_q;
  assign level     = level_q;

endmodule

// File: doc/async_hs_rx.md
# async_hs_rx

Clocked receiver for a 4-phase bundled-data asynchronous channel, such as the output of a C-element Muller pipeline. It synchronizes the incoming request, captures the bundled data word, returns a registered acknowledge, and buffers captured words in a small FIFO. The FIFO is drained through a synchronous valid/ready port. The block is the synchronous end of the async handshake path in the tile, sitting between the self-timed pipeline and clocked logic.

## Interface
Parameters:
- WIDTH, 8, data word width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- SYNC_STAGES, 2, flops in the req synchronizer (≥2)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req_in  input  1  async 4-phase request from producer
- data_in  input  WIDTH  bundled data; stable from before req_in rises until ack_out rises
- ack_out  output  1  4-phase acknowledge, driven directly from a flop
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head word
- out_data  output  WIDTH  FIFO head word
- level  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- req_in passes through SYNC_STAGES flops, all reset to 0; req_s is the last stage.
- FSM states: RST_WAIT, IDLE, ACK_HI.
  - RST_WAIT: entered on reset. ack_out=0. Go to IDLE when req_s==0. This prevents re-capturing a request that was in flight at reset.
  - IDLE: ack_out=0. When req_s==1 and level<DEPTH: push data_in into the FIFO, set ack_out=1, go to ACK_HI. When req_s==1 and full: stay in IDLE with ack withheld. No data is dropped.
  - ACK_HI: ack_out=1. When req_s==0: set ack_out=0, go to IDLE.
- The full check uses registered level. A pop in the same cycle does not enable a push; the push happens on the next cycle.
- FIFO: circular buffer with wrapping read/write pointers of width $clog2(DEPTH).
  - out_data = mem[rd_ptr].
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop with 0<level<DEPTH leaves level unchanged.
  - With level==0 there is no pop. A push is visible on out_valid the cycle after capture; there is no bypass.
- data_in is sampled in the capture cycle only and is never resynchronized. The bundled-data constraint guarantees it is stable.

## Timing
- Reset values: ack_out=0, out_valid=0, level=0, out_data=0 (memory cleared), state=RST_WAIT, pointers=0.
- Reset is asynchronous: asserting rst_n mid-handshake drops ack_out immediately and discards FIFO contents.
- req_in rise to ack_out rise: SYNC_STAGES+1 clk edges (3 by default), given the FIFO is not full.
- req_in fall to ack_out fall: SYNC_STAGES+1 edges (3 by default).
- Capture to out_valid: 1 cycle.
- Peak throughput: one word per 2·(SYNC_STAGES+1) cycles plus producer response delay.
- ack_out never glitches; it changes at most once per clock edge and only on FSM transitions.
- Full FIFO: ack stays low. Ack rises the first cycle after the registered level drops below DEPTH and req_s==1.

## Test plan
- Reset and single transfer: hold rst_n=0 with req_in=0. After release, drive data_in=0xA5 and raise req_in.
  - ack_out rises on the 3rd edge.
  - Drop req_in; ack_out falls 3 edges later.
  - out_valid=1, out_data=0xA5, level=1; pop with out_ready=1 leaves level=0.
- Burst to full: out_ready=0, four handshakes with 0x01..0x04 → level=4.
  - A fifth request (0x05) gets no ack for 20 cycles.
  - Pulse out_ready for one cycle: head 0x01 pops, and ack rises no earlier than 1 cycle after level=3.
  - Drain order is 0x02, 0x03, 0x04, 0x05.
- Wrap-around: ten transfers 0x10..0x19 with out_ready=1 always. Output sequence is exact, level never exceeds 1, pointers wrap twice.
- Simultaneous push/pop: with level=2, hold out_ready=1 in the capture cycle → level stays 2 and ordering is preserved.
- Reset mid-handshake: assert rst_n while in ACK_HI with req_in=1.
  - ack_out=0 immediately and level=0.
  - After release with req_in still 1: no capture and ack stays 0.
  - Lower then raise req_in with 0x3C: one capture of 0x3C.
- Async req jitter: randomize req_in edges relative to clk over 1000 transfers against a producer model that honours the 4-phase protocol.
  - No lost or duplicated words.
  - ack_out toggles exactly twice per word.
